cache_refill_ctrl: RTL

Read-path controller between the CPU load port and the direct-mapped data cache (1024 lines × 4 words, 3-bit tag, 15-bit word address). It latches a CPU read request and performs a lookup. On a hit it returns the cached word. On a miss it fetches the 4-word block from main memory over a req/ack handshake, assembles the 128-bit line, writes it into the cache and returns the requested word. One outstanding request; no write path.

---
 rtl/cache_pkg.sv | 24 ++
 rtl/cache_refill_ctrl_if.sv | 31 +++
 rtl/cache_refill_ctrl_refill_buf.sv | 33 +++
 rtl/cache_refill_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and sizes for the cache read-path controller: 15-bit word address
// split as tag[14:12] / index[11:2] / offset[1:0], 4 x 32-bit words per line.
package cache_pkg;
  localparam int ADDR_W     = 15;
  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int TAG_W      = 3;
  localparam int INDEX_W    = 10;
  localparam int OFF_W      = 2;

  typedef logic [LINE_WORDS*WORD_W-1:0] line_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL,
    ST_WRITE,
    ST_RESPOND
  } state_e;

  function automatic logic [WORD_W-1:0] word_sel(input line_t line, input logic [OFF_W-1:0] off);
    return line[off*WORD_W +: WORD_W];
  endfunction
endpackage

// File: rtl/cache_refill_ctrl_if.sv
// CPU load port, cache array port and memory read port of the refill controller.
// master = controller side, slave = CPU/cache/memory side.
interface cache_refill_ctrl_if;
  logic                          cpu_req;
  logic [cache_pkg::ADDR_W-1:0]  cpu_addr;
  logic                          cpu_busy;
  logic                          cpu_valid;
  logic [cache_pkg::WORD_W-1:0]  cpu_data;
  logic [cache_pkg::ADDR_W-1:0]  cache_addr;
  logic                          cache_re;
  logic                          cache_we;
  cache_pkg::line_t              cache_wdata;
  logic                          cache_hit;
  logic [cache_pkg::WORD_W-1:0]  cache_rdata;
  logic                          mem_req;
  logic [cache_pkg::ADDR_W-1:0]  mem_addr;
  logic                          mem_ack;
  logic [cache_pkg::WORD_W-1:0]  mem_rdata;

  modport master (
    input  cpu_req, cpu_addr, cache_hit, cache_rdata, mem_ack, mem_rdata,
    output cpu_busy, cpu_valid, cpu_data, cache_addr, cache_re, cache_we,
           cache_wdata, mem_req, mem_addr
  );

  modport slave (
    output cpu_req, cpu_addr, cache_hit, cache_rdata, mem_ack, mem_rdata,
    input  cpu_busy, cpu_valid, cpu_data, cache_addr, cache_re, cache_we,
           cache_wdata, mem_req, mem_addr
  );
endinterface

// File: rtl/cache_refill_ctrl_refill_buf.sv
// Line assembly buffer: stores one memory word per accepted beat, beat counter wraps
// after the last word; done_o flags the ack that completes the line.
module refill_buf
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              ack_i,
  input  logic [WORD_W-1:0] rdata_i,
  output line_t             line_o,
  output logic [OFF_W-1:0]  beat_o,
  output logic              done_o
);
  logic [LINE_WORDS-1:0][WORD_W-1:0] buf_q;
  logic [OFF_W-1:0]                  beat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q  <= '0;
      beat_q <= '0;
    end else if (clr_i) begin
      beat_q <= '0;
    end else if (ack_i) begin
      buf_q[beat_q] <= rdata_i;
      beat_q        <= beat_q + OFF_W'(1);
    end
  end

  assign line_o = buf_q;
  assign beat_o = beat_q;
  assign done_o = ack_i && (beat_q == OFF_W'(LINE_WORDS-1));
endmodule

// File: rtl/cache_refill_ctrl.sv
// Read-path controller: lookup, 4-beat refill on miss, line write, one response per request.
// Hit responds one cycle after LOOKUP; miss adds one cycle per memory beat plus wait cycles. CACHE_STATS_EN adds hit/miss counters.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  cache_refill_ctrl_if.master  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);
  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  data_q, data_d;
  line_t              line;
  logic [OFF_W-1:0]   beat;
  logic               done;
  logic               beat_clr;
  logic               beat_ack;

  refill_buf u_refill_buf (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (beat_clr),
    .ack_i   (beat_ack),
    .rdata_i (bus.mem_rdata),
    .line_o  (line),
    .beat_o  (beat),
    .done_o  (done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    beat_clr      = 1'b0;
    beat_ack      = 1'b0;
    bus.cache_re  = 1'b0;
    bus.cache_we  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.cpu_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        bus.cache_re = 1'b1;
        if (bus.cache_hit) begin
          data_d  = bus.cache_rdata;
          state_d = ST_RESPOND;
        end else begin
          beat_clr = 1'b1;
          state_d  = ST_REFILL;
        end
      end
      ST_REFILL: begin
        bus.mem_req = 1'b1;
        beat_ack    = bus.mem_ack;
        if (done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        // Line is complete here; the requested word comes straight from the buffer.
        bus.cache_we = 1'b1;
        data_d       = word_sel(line, addr_q[OFF_W-1:0]);
        state_d      = ST_RESPOND;
      end
      ST_RESPOND: begin
        bus.cpu_valid = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cpu_busy    = (state_q != ST_IDLE);
  assign bus.cpu_data    = data_q;
  assign bus.cache_addr  = addr_q;
  assign bus.cache_wdata = line;
  assign bus.mem_addr    = {addr_q[ADDR_W-1:OFF_W], beat};

`ifdef CACHE_STATS_EN
  logic [15:0] hit_q, miss_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == ST_LOOKUP) begin
      if (bus.cache_hit && hit_q != 16'hFFFF)   hit_q  <= hit_q + 16'd1;
      if (!bus.cache_hit && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif
endmodule
